// File: rtl/l2_cache_controller.sv
// Direct-mapped, write-back L2 cache controller.
// One request at a time from the L1 mux; hits are served from local arrays,
// misses write back a dirty victim and/or fill the line from main memory.
//
// state     | meaning
// IDLE      | waiting for a read or write-back request from L1
// COMPARE   | tag lookup on the latched request
// WRITEBACK | dirty victim being written to memory
// ALLOCATE  | line being filled from memory (reads only)
// DONE      | one-cycle completion pulse to L1
module l2_cache_controller #(
  parameter int INDEX_W = 4,
  parameter int TAG_W   = 22,
  parameter int BLOCK_W = 128
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     read_L1_L2,
  input  logic                     write_L1_L2,
  input  logic [INDEX_W-1:0]       index_L1_L2,
  input  logic [TAG_W-1:0]         tag_L1_L2,
  input  logic [BLOCK_W-1:0]       write_data_L1_L2,
  output logic                     ready_L2_L1,
  output logic [BLOCK_W-1:0]       read_data_L2_L1,
  output logic                     read_L2_MEM,
  output logic                     write_L2_MEM,
  output logic [TAG_W+INDEX_W-1:0] address_L2_MEM,
  output logic [BLOCK_W-1:0]       write_data_L2_MEM,
  input  logic [BLOCK_W-1:0]       read_data_MEM_L2,
  input  logic                     ready_MEM_L2
);

  localparam int LINES = 1 << INDEX_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COMPARE,
    S_WRITEBACK,
    S_ALLOCATE,
    S_DONE
  } state_t;

  state_t                   r_state;
  logic [LINES-1:0]         r_valid;
  logic [LINES-1:0]         r_dirty;
  logic [TAG_W-1:0]         r_tag_arr  [LINES];
  logic [BLOCK_W-1:0]       r_data_arr [LINES];

  logic [INDEX_W-1:0]       r_req_idx;
  logic [TAG_W-1:0]         r_req_tag;
  logic [BLOCK_W-1:0]       r_req_wdata;
  logic                     r_req_is_read;

  logic                     r_ready;
  logic [BLOCK_W-1:0]       r_rdata;
  logic                     r_mem_rd;
  logic                     r_mem_wr;
  logic [TAG_W+INDEX_W-1:0] r_mem_addr;
  logic [BLOCK_W-1:0]       r_mem_wdata;

  logic [TAG_W-1:0]         w_line_tag;
  logic [BLOCK_W-1:0]       w_line_data;
  logic                     w_hit;
  logic                     w_victim_dirty;
  logic                     w_arr_we;
  logic [TAG_W-1:0]         w_arr_wtag;
  logic [BLOCK_W-1:0]       w_arr_wdata;

  // Lookup of the addressed line and the single write port into tag/data arrays
  always_comb begin
    w_line_tag     = r_tag_arr[r_req_idx];
    w_line_data    = r_data_arr[r_req_idx];
    w_hit          = r_valid[r_req_idx] && (w_line_tag == r_req_tag);
    w_victim_dirty = r_valid[r_req_idx] && r_dirty[r_req_idx];
    w_arr_we       = 1'b0;
    w_arr_wtag     = r_req_tag;
    w_arr_wdata    = r_req_wdata;
    if (r_state == S_COMPARE && !r_req_is_read && (w_hit || !w_victim_dirty)) begin
      w_arr_we = 1'b1;
    end else if (r_state == S_ALLOCATE && ready_MEM_L2) begin
      w_arr_we    = 1'b1;
      w_arr_wdata = read_data_MEM_L2;
    end
  end

  // Tag/data storage is deliberately not reset; valid bits gate its use
  always_ff @(posedge clk) begin
    if (w_arr_we) begin
      r_tag_arr[r_req_idx]  <= w_arr_wtag;
      r_data_arr[r_req_idx] <= w_arr_wdata;
    end
  end

  // Controller FSM with valid/dirty bookkeeping and registered Moore outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_valid       <= '0;
      r_dirty       <= '0;
      r_req_idx     <= '0;
      r_req_tag     <= '0;
      r_req_wdata   <= '0;
      r_req_is_read <= 1'b0;
      r_ready       <= 1'b0;
      r_rdata       <= '0;
      r_mem_rd      <= 1'b0;
      r_mem_wr      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
    end else begin
      r_ready <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (read_L1_L2 || write_L1_L2) begin
            r_req_idx     <= index_L1_L2;
            r_req_tag     <= tag_L1_L2;
            r_req_wdata   <= write_data_L1_L2;
            r_req_is_read <= read_L1_L2;
            r_state       <= S_COMPARE;
          end
        end
        S_COMPARE: begin
          if (w_hit) begin
            if (r_req_is_read) r_rdata <= w_line_data;
            else               r_dirty[r_req_idx] <= 1'b1;
            r_ready <= 1'b1;
            r_state <= S_DONE;
          end else if (w_victim_dirty) begin
            r_mem_wr    <= 1'b1;
            r_mem_addr  <= {w_line_tag, r_req_idx};
            r_mem_wdata <= w_line_data;
            r_state     <= S_WRITEBACK;
          end else if (r_req_is_read) begin
            r_mem_rd   <= 1'b1;
            r_mem_addr <= {r_req_tag, r_req_idx};
            r_state    <= S_ALLOCATE;
          end else begin
            // clean write miss: the whole line is supplied, so no fill needed
            r_valid[r_req_idx] <= 1'b1;
            r_dirty[r_req_idx] <= 1'b1;
            r_ready            <= 1'b1;
            r_state            <= S_DONE;
          end
        end
        S_WRITEBACK: begin
          if (ready_MEM_L2) begin
            r_mem_wr           <= 1'b0;
            r_dirty[r_req_idx] <= 1'b0;
            if (r_req_is_read) begin
              r_mem_rd   <= 1'b1;
              r_mem_addr <= {r_req_tag, r_req_idx};
              r_state    <= S_ALLOCATE;
            end else begin
              r_state <= S_COMPARE;
            end
          end
        end
        S_ALLOCATE: begin
          if (ready_MEM_L2) begin
            r_mem_rd           <= 1'b0;
            r_valid[r_req_idx] <= 1'b1;
            r_dirty[r_req_idx] <= 1'b0;
            r_state            <= S_COMPARE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ready_L2_L1       = r_ready;
  assign read_data_L2_L1   = r_rdata;
  assign read_L2_MEM       = r_mem_rd;
  assign write_L2_MEM      = r_mem_wr;
  assign address_L2_MEM    = r_mem_addr;
  assign write_data_L2_MEM = r_mem_wdata;

endmodule

// File: tb/tb_l2_cache_controller.sv
// Scoreboard bench for l2_cache_controller: a line-level cache model predicts
// L1 responses and memory transactions; separate monitors check both sides.
module tb_l2_cache_controller;

  localparam int IW = 4;
  localparam int TW = 22;
  localparam int BW = 128;
  localparam int AW = TW + IW;

  logic          clk = 1'b0;
  logic          rst;
  logic          read_L1_L2, write_L1_L2;
  logic [IW-1:0] index_L1_L2;
  logic [TW-1:0] tag_L1_L2;
  logic [BW-1:0] write_data_L1_L2;
  logic          ready_L2_L1;
  logic [BW-1:0] read_data_L2_L1;
  logic          read_L2_MEM, write_L2_MEM;
  logic [AW-1:0] address_L2_MEM;
  logic [BW-1:0] write_data_L2_MEM;
  logic [BW-1:0] read_data_MEM_L2;
  logic          ready_MEM_L2;

  l2_cache_controller #(.INDEX_W(IW), .TAG_W(TW), .BLOCK_W(BW)) dut (
    .clk(clk), .rst(rst),
    .read_L1_L2(read_L1_L2), .write_L1_L2(write_L1_L2),
    .index_L1_L2(index_L1_L2), .tag_L1_L2(tag_L1_L2),
    .write_data_L1_L2(write_data_L1_L2),
    .ready_L2_L1(ready_L2_L1), .read_data_L2_L1(read_data_L2_L1),
    .read_L2_MEM(read_L2_MEM), .write_L2_MEM(write_L2_MEM),
    .address_L2_MEM(address_L2_MEM), .write_data_L2_MEM(write_data_L2_MEM),
    .read_data_MEM_L2(read_data_MEM_L2), .ready_MEM_L2(ready_MEM_L2)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [BW-1:0] data;
  } mop_t;

  int total = 0;
  int bad   = 0;
  int lat_cfg = 0;

  logic [BW-1:0] exp_resp[$];
  mop_t          exp_mem[$];

  // reference model state
  bit            m_valid [16];
  bit            m_dirty [16];
  logic [TW-1:0] m_tag   [16];
  logic [BW-1:0] m_data  [16];
  logic [BW-1:0] m_mem   [logic [AW-1:0]];
  logic [BW-1:0] m_last_rd;

  // memory responder storage
  logic [BW-1:0] mem_r   [logic [AW-1:0]];

  task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [BW-1:0] mem_init(input logic [AW-1:0] a);
    return {4{6'h2A, a}};
  endfunction

  function automatic logic [BW-1:0] model_mem_rd(input logic [AW-1:0] a);
    if (m_mem.exists(a)) return m_mem[a];
    return mem_init(a);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0;
      m_dirty[i] = 0;
    end
    m_last_rd = '0;
  endtask

  // Line-level behaviour: returns 2 when a fixed-latency (no memory) path is expected
  task automatic model_req(input bit rd, input logic [IW-1:0] idx, input logic [TW-1:0] tag,
                           input logic [BW-1:0] wd, output int exp_lat);
    mop_t op;
    exp_lat = 0;
    if (m_valid[idx] && m_tag[idx] == tag) begin
      exp_lat = 2;
      if (rd) m_last_rd = m_data[idx];
      else begin m_data[idx] = wd; m_dirty[idx] = 1; end
    end else begin
      if (m_valid[idx] && m_dirty[idx]) begin
        op.wr = 1; op.addr = {m_tag[idx], idx}; op.data = m_data[idx];
        exp_mem.push_back(op);
        m_mem[op.addr] = m_data[idx];
      end else if (!rd) begin
        exp_lat = 2;
      end
      m_valid[idx] = 1;
      m_tag[idx]   = tag;
      if (rd) begin
        op.wr = 0; op.addr = {tag, idx}; op.data = '0;
        exp_mem.push_back(op);
        m_data[idx]  = model_mem_rd({tag, idx});
        m_dirty[idx] = 0;
        m_last_rd    = m_data[idx];
      end else begin
        m_data[idx]  = wd;
        m_dirty[idx] = 1;
      end
    end
    exp_resp.push_back(m_last_rd);
  endtask

  task automatic do_req(input bit rd, input bit wr, input logic [IW-1:0] idx,
                        input logic [TW-1:0] tag, input logic [BW-1:0] wd);
    int exp_lat;
    int n;
    bit seen;
    model_req(rd, idx, tag, wd, exp_lat);
    @(negedge clk);
    read_L1_L2 = rd; write_L1_L2 = wr;
    index_L1_L2 = idx; tag_L1_L2 = tag; write_data_L1_L2 = wd;
    n = 0; seen = 0;
    while (!seen && n < 200) begin
      @(negedge clk);
      n++;
      if (ready_L2_L1) seen = 1;
    end
    if (!seen) begin
      total++; bad++;
      $display("FAIL req_timeout: idx=%0d tag=%h no ready after %0d cycles", idx, tag, n);
    end else if (exp_lat > 0) begin
      chk("req_latency", BW'(n), BW'(exp_lat));
    end
    read_L1_L2 = 0; write_L1_L2 = 0;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [BW-1:0] d);
    mem_r[a] = d;
    m_mem[a] = d;
  endtask

  // L1-side monitor: every completion pulse is matched against the scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && ready_L2_L1) begin
        if (exp_resp.size() == 0) begin
          total++; bad++;
          $display("FAIL resp_unexpected: got ready with data %h", read_data_L2_L1);
        end else begin
          chk("resp_data", read_data_L2_L1, exp_resp.pop_front());
        end
      end
    end
  end

  // Memory responder and memory-side monitor
  initial begin
    bit            busy = 0;
    int            cnt = 0;
    logic          cur_wr = 0;
    logic [AW-1:0] cur_addr = '0;
    logic [BW-1:0] cur_data = '0;
    mop_t          e;
    ready_MEM_L2 = 0;
    read_data_MEM_L2 = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy = 0; ready_MEM_L2 = 0;
        continue;
      end
      if (read_L2_MEM && write_L2_MEM) begin
        total++; bad++;
        $display("FAIL mem_rd_wr_both: read=1 write=1 addr=%h", address_L2_MEM);
      end
      if (ready_MEM_L2) begin
        ready_MEM_L2 = 0;
        busy = 0;
      end
      if (!busy && (read_L2_MEM || write_L2_MEM)) begin
        busy = 1;
        cur_wr = write_L2_MEM; cur_addr = address_L2_MEM; cur_data = write_data_L2_MEM;
        cnt = (lat_cfg > 0) ? lat_cfg : int'($urandom_range(1, 4));
        if (exp_mem.size() == 0) begin
          total++; bad++;
          $display("FAIL mem_unexpected: wr=%0d addr=%h", cur_wr, cur_addr);
        end else begin
          e = exp_mem.pop_front();
          chk("mem_kind", BW'(cur_wr), BW'(e.wr));
          chk("mem_addr", BW'(cur_addr), BW'(e.addr));
          if (e.wr) chk("mem_wdata", cur_data, e.data);
        end
      end else if (busy) begin
        chk("mem_req_held", BW'(cur_wr ? write_L2_MEM : read_L2_MEM), BW'(1));
        chk("mem_addr_stable", BW'(address_L2_MEM), BW'(cur_addr));
      end
      if (busy && !ready_MEM_L2) begin
        cnt--;
        if (cnt <= 0) begin
          ready_MEM_L2 = 1;
          if (cur_wr) mem_r[cur_addr] = cur_data;
          else read_data_MEM_L2 = mem_r.exists(cur_addr) ? mem_r[cur_addr] : mem_init(cur_addr);
        end
      end
    end
  end

  initial begin
    logic [BW-1:0] d;
    logic [AW-1:0] a;
    int n;
    mop_t op;
    rst = 1;
    read_L1_L2 = 0; write_L1_L2 = 0;
    index_L1_L2 = '0; tag_L1_L2 = '0; write_data_L1_L2 = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_ready", BW'(ready_L2_L1), BW'(0));
    chk("rst_rdata", read_data_L2_L1, '0);
    chk("rst_mem_rd", BW'(read_L2_MEM), BW'(0));
    chk("rst_mem_wr", BW'(write_L2_MEM), BW'(0));
    chk("rst_mem_addr", BW'(address_L2_MEM), '0);
    chk("rst_mem_wdata", write_data_L2_MEM, '0);
    rst = 0;

    // cold read miss, hit, dirty-victim eviction
    lat_cfg = 3;
    d = {16{8'hAA}};
    a = 26'h013;
    preload(a, d);
    do_req(1, 0, 4'd3, 22'h1, '0);
    do_req(1, 0, 4'd3, 22'h1, '0);
    do_req(0, 1, 4'd3, 22'h1, {16{8'h55}});
    do_req(1, 0, 4'd3, 22'h2, '0);
    lat_cfg = 0;

    // clean write miss installs without traffic, then reads back
    do_req(0, 1, 4'd5, 22'h7, {4{32'h1234_5678}});
    do_req(1, 0, 4'd5, 22'h7, '0);

    // read and write together: read wins, write re-presented afterwards
    do_req(1, 1, 4'd1, 22'h4, {4{32'hDEAD_BEEF}});
    do_req(0, 1, 4'd1, 22'h4, {4{32'hDEAD_BEEF}});
    do_req(1, 0, 4'd1, 22'h4, '0);

    // write miss onto a dirty victim: writeback, then direct install
    do_req(0, 1, 4'd1, 22'h9, {4{32'hCAFE_F00D}});
    do_req(1, 0, 4'd1, 22'h9, '0);

    // reset during ALLOCATE abandons the fill
    lat_cfg = 20;
    op.wr = 0; op.addr = {22'h3A, 4'd9}; op.data = '0;
    exp_mem.push_back(op);
    @(negedge clk);
    read_L1_L2 = 1; index_L1_L2 = 4'd9; tag_L1_L2 = 22'h3A;
    n = 0;
    while (!read_L2_MEM && n < 20) begin @(negedge clk); n++; end
    chk("alloc_reached", BW'(read_L2_MEM), BW'(1));
    @(negedge clk);
    #2 rst = 1;
    #1 chk("rst_drops_mem_rd", BW'(read_L2_MEM), BW'(0));
    chk("rst_drops_ready", BW'(ready_L2_L1), BW'(0));
    read_L1_L2 = 0;
    model_reset();
    @(negedge clk);
    rst = 0;
    lat_cfg = 0;
    do_req(1, 0, 4'd9, 22'h3A, '0);
    do_req(1, 0, 4'd5, 22'h7, '0);

    // randomized traffic over a few sets and tags to force conflicts
    for (int i = 0; i < 200; i++) begin
      bit rd, wr;
      rd = 1'($urandom_range(0, 1));
      wr = rd ? ($urandom_range(0, 7) == 0) : 1'b1;
      do_req(rd, wr, 4'($urandom_range(0, 3)), 22'($urandom_range(0, 3)),
             {$urandom, $urandom, $urandom, $urandom});
    end

    repeat (5) @(negedge clk);
    chk("resp_queue_empty", BW'(exp_resp.size()), '0);
    chk("mem_queue_empty", BW'(exp_mem.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
